// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a decoded micro-op descriptor into a 32-bit word and buffers it in a FIFO.
// Optional statistics counters (enc_count, err_count) are enabled with `define INSTR_ENCODER_STATS_EN.
module instr_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_alu,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err
`ifdef INSTR_ENCODER_STATS_EN
  ,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] CL_LOAD   = 3'd0;
  localparam logic [2:0] CL_STORE  = 3'd1;
  localparam logic [2:0] CL_OPIMM  = 3'd2;
  localparam logic [2:0] CL_OP     = 3'd3;
  localparam logic [2:0] CL_BRANCH = 3'd4;
  localparam logic [2:0] CL_JAL    = 3'd5;
  localparam logic [2:0] CL_LUI    = 3'd6;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ---------------- encode / legality ----------------
  logic [2:0]  f3;
  logic        alu_ok;
  logic        imm12_ok, imm13_ok, imm21_ok;
  logic        legal;
  logic [31:0] word;

  // Range checks: all bits above the field's sign bit must replicate it.
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm13_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm21_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  always_comb begin
    f3 = 3'b000;
    case (in_alu)
      ALU_SLT: f3 = 3'b010;
      ALU_OR:  f3 = 3'b110;
      ALU_AND: f3 = 3'b111;
      default: f3 = 3'b000;
    endcase
  end

  assign alu_ok = (in_alu == ALU_ADD) | (in_alu == ALU_SUB) | (in_alu == ALU_AND) |
                  (in_alu == ALU_OR)  | (in_alu == ALU_SLT);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (in_class)
      CL_LOAD: begin
        legal = (in_alu == ALU_ADD) & imm12_ok;
        word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      end
      CL_STORE: begin
        legal = (in_alu == ALU_ADD) & imm12_ok;
        word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      CL_OPIMM: begin
        legal = alu_ok & (in_alu != ALU_SUB) & imm12_ok;
        word  = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
      end
      CL_OP: begin
        legal = alu_ok;
        word  = {1'b0, (in_alu == ALU_SUB), 5'b00000, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      end
      CL_BRANCH: begin
        legal = (in_alu == ALU_SUB) & imm13_ok;
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                 in_imm[4:1], in_imm[11], 7'b1100011};
      end
      CL_JAL: begin
        legal = (in_alu == ALU_ADD) & imm21_ok;
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      end
      CL_LUI: begin
        legal = (in_alu == ALU_ADD);
        word  = {in_imm[31:12], in_rd, 7'b0110111};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  // ---------------- FIFO ----------------
  logic [DEPTH-1:0][31:0] mem_q;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, out_valid_q, err_q;
  logic [31:0]            head_q, head_d;
  logic                   accept, push, pop;

  assign in_ready  = ~full_q;
  assign out_valid = out_valid_q;
  assign out_instr = head_q;
  assign err       = err_q;

  assign accept = in_valid & ~full_q;
  assign push   = accept & legal;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next head: the word being written this cycle if it lands at the new read slot.
  always_comb begin
    head_d = '0;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = word;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CW'(DEPTH));
      out_valid_q <= (count_d != '0);
      head_q      <= head_d;
      err_q       <= accept & ~legal;
    end
  end

`ifdef INSTR_ENCODER_STATS_EN
  logic [15:0] enc_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push && (enc_cnt_q != 16'hFFFF))              enc_cnt_q <= enc_cnt_q + 16'd1;
      if (accept && !legal && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, FIFO fill/drain, illegal descriptors,
// mid-run reset, then randomized traffic against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  in_class, in_alu;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;
`ifdef INSTR_ENCODER_STATS_EN
  logic [15:0] enc_count, err_count;
`endif

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_alu(in_alu),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err)
`ifdef INSTR_ENCODER_STATS_EN
    , .enc_count(enc_count), .err_count(err_count)
`endif
  );

  int          n_chk = 0, n_fail = 0;
  logic [31:0] mq[$];
  bit          m_err;
  int          m_enc_cnt, m_err_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference encoding from the format tables, using shifts and masks on integers.
  function automatic logic [31:0] m_enc(int cls, int alu, int rd, int rs1, int rs2, int imm);
    int f3, r;
    f3 = (alu == 5) ? 2 : (alu == 3) ? 6 : (alu == 2) ? 7 : 0;
    r = 0;
    case (cls)
      0: r = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      1: r = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
             ((imm & 'h1F) << 7) | 'h23;
      2: r = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
      3: r = ((alu == 1) ? (1 << 30) : 0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             (rd << 7) | 'h33;
      4: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) |
             (rs1 << 15) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      5: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      6: r = (imm & 32'hFFFFF000) | (rd << 7) | 'h37;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  function automatic bit m_legal(int cls, int alu, int imm);
    if (cls == 7) return 0;
    if (!(alu == 0 || alu == 1 || alu == 2 || alu == 3 || alu == 5)) return 0;
    if (cls == 2 && alu == 1) return 0;
    if ((cls == 0 || cls == 1 || cls == 5 || cls == 6) && alu != 0) return 0;
    if (cls == 4 && alu != 1) return 0;
    if ((cls == 0 || cls == 1 || cls == 2) && (imm < -2048 || imm > 2047)) return 0;
    if (cls == 4 && (imm < -4096 || imm > 4094 || (imm % 2) != 0)) return 0;
    if (cls == 5 && (imm < -1048576 || imm > 1048574 || (imm % 2) != 0)) return 0;
    return 1;
  endfunction

  task automatic drive(input int cls, input int alu, input int rd, input int rs1,
                       input int rs2, input int imm);
    in_class = 3'(cls); in_alu = 3'(alu);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = 32'(imm);
  endtask

  // One clock: predict from current inputs, advance the model at the edge, compare after it.
  task automatic step();
    bit acc, pop, lg;
    logic [31:0] w;
    acc = rst_n && in_valid && (mq.size() < DEPTH);
    pop = rst_n && out_ready && (mq.size() > 0);
    lg  = m_legal(int'(in_class), int'(in_alu), $signed(in_imm));
    w   = m_enc(int'(in_class), int'(in_alu), int'(in_rd), int'(in_rs1), int'(in_rs2),
                $signed(in_imm));
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_err = 0; m_enc_cnt = 0; m_err_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && lg) begin
        mq.push_back(w);
        if (m_enc_cnt < 65535) m_enc_cnt++;
      end
      m_err = acc && !lg;
      if (acc && !lg && m_err_cnt < 65535) m_err_cnt++;
    end
    #1;
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (mq.size() > 0) chk("out_instr", out_instr, mq[0]);
`ifdef INSTR_ENCODER_STATS_EN
    chk("enc_count", {16'b0, enc_count}, 32'(m_enc_cnt));
    chk("err_count", {16'b0, err_count}, 32'(m_err_cnt));
`endif
  endtask

  task automatic rand_desc();
    int cls, alu, imm, sel;
    cls = int'($urandom_range(0, 7));
    if ($urandom_range(0, 9) < 8) begin
      case (cls)
        2: begin sel = int'($urandom_range(0, 3)); alu = (sel == 0) ? 0 : (sel == 1) ? 2 : (sel == 2) ? 3 : 5; end
        3: begin sel = int'($urandom_range(0, 4)); alu = (sel == 4) ? 5 : sel; end
        4: alu = 1;
        default: alu = 0;
      endcase
    end else alu = int'($urandom_range(0, 7));
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: imm = int'($urandom_range(0, 4200)) - 2100;
      1: imm = (int'($urandom_range(0, 4300)) - 2150) * 2 + int'($urandom_range(0, 7) == 0);
      2: imm = (int'($urandom_range(0, 1100000)) - 550000) * 2 + int'($urandom_range(0, 7) == 0);
      default: imm = int'($urandom);
    endcase
    drive(cls, alu, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), imm);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_err = 0; m_enc_cnt = 0; m_err_cnt = 0;

    // Pin the reference model against hand-encoded words.
    chk("model_addi", m_enc(2, 0, 1, 0, 0, 5), 32'h00500093);
    chk("model_add",  m_enc(3, 0, 3, 1, 2, 0), 32'h002081B3);
    chk("model_sub",  m_enc(3, 1, 3, 1, 2, 0), 32'h402081B3);
    chk("model_lw",   m_enc(0, 0, 2, 0, 0, 8), 32'h00802103);
    chk("model_beq",  m_enc(4, 1, 0, 1, 2, -4), 32'hFE208EE3);
    chk("model_ill_imm", {31'b0, m_legal(2, 0, 4096)}, 32'd0);
    chk("model_ill_odd", {31'b0, m_legal(4, 1, 3)}, 32'd0);

    step(); step();
    chk("reset_out_instr", out_instr, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Directed encodings, streaming with out_ready high.
    out_ready = 1'b1; in_valid = 1'b1;
    drive(2, 0, 1, 0, 0, 5);  step(); chk("t_addi", out_instr, 32'h00500093);
    chk("t_addi_err", {31'b0, err}, 32'd0);
    drive(3, 0, 3, 1, 2, 0);  step(); chk("t_add", out_instr, 32'h002081B3);
    drive(3, 1, 3, 1, 2, 0);  step(); chk("t_sub", out_instr, 32'h402081B3);
    drive(0, 0, 2, 0, 0, 8);  step(); chk("t_lw", out_instr, 32'h00802103);
    drive(4, 1, 0, 1, 2, -4); step(); chk("t_beq", out_instr, 32'hFE208EE3);
    in_valid = 1'b0; step(); step();

    // Fill with consumer stalled; third descriptor must be held.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(2, 0, 1, 0, 0, 5); step();
    drive(3, 0, 3, 1, 2, 0); step();
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    drive(0, 0, 2, 0, 0, 8); step(); step();
    chk("full_held", {31'b0, in_ready}, 32'd0);
    chk("full_head", out_instr, 32'h00500093);
    out_ready = 1'b1;
    step(); chk("drain_1", out_instr, 32'h002081B3);
    step(); chk("drain_2", out_instr, 32'h00802103);
    in_valid = 1'b0;
    step(); chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Mid-operation reset discards buffered words.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(2, 0, 1, 0, 0, 5); step();
    drive(3, 0, 3, 1, 2, 0); step();
    in_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);

    // Illegal descriptors: accepted, not pushed, one-cycle err each.
    in_valid = 1'b1;
    drive(2, 0, 1, 0, 0, 4096); step();
    chk("ill_imm_err", {31'b0, err}, 32'd1);
    drive(4, 1, 0, 1, 2, 3); step();
    chk("ill_odd_err", {31'b0, err}, 32'd1);
    chk("ill_no_push", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0; step();
    chk("ill_err_drop", {31'b0, err}, 32'd0);
`ifdef INSTR_ENCODER_STATS_EN
    chk("stat_err2", {16'b0, err_count}, 32'd2);
    chk("stat_enc0", {16'b0, enc_count}, 32'd0);
`endif
    out_ready = 1'b1; in_valid = 1'b1;
    drive(0, 0, 2, 0, 0, 8); step();
    chk("post_rst_lw", out_instr, 32'h00802103);
    in_valid = 1'b0; step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_desc();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder, the inverse of the single-cycle controller's decode path.
- Accepts a decoded micro-op descriptor (class, ALUControl code, register indices, immediate) over a valid/ready handshake.
- Packs the descriptor into a 32-bit instruction word and buffers it in a small output FIFO.
- Used by self-test program generators and the instruction-memory loader to produce words that the controller decodes back to the same ALUControl/ImmSrc.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  descriptor valid
- in_ready  output  1  encoder can accept a descriptor
- in_class  input  3  0 LOAD(lw), 1 STORE(sw), 2 OPIMM, 3 OP, 4 BRANCH(beq), 5 JAL, 6 LUI, 7 reserved
- in_alu  input  3  ALUControl code: 000 add, 001 sub, 010 and, 011 or, 101 slt
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  immediate or byte offset, two's complement
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_instr  output  32  FIFO head instruction word
- err  output  1  one-cycle pulse: last accepted descriptor was illegal

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO empty; out_valid=0, out_instr=0, err=0, in_ready=1.
  - Applies mid-operation: buffered words are discarded.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full, registered from the occupancy count. A push is not allowed at full even if a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
- Latency: an accepted legal word appears on out_instr with out_valid=1 on the next cycle if the FIFO was empty. out_instr is a registered read of the head.
- Encoding:
  - LOAD: op 0000011, f3 010, imm[11:0].
  - STORE: op 0100011, f3 010, imm split [11:5]/[4:0].
  - OPIMM: op 0010011, imm[11:0], f3 from alu (add 000, slt 010, or 110, and 111).
  - OP: op 0110011, f3 as OPIMM; sub encodes f3 000 with funct7b5=1, all others funct7=0.
  - BRANCH: op 1100011, f3 000, B-type scramble of imm[12:1].
  - JAL: op 1101111, J-type scramble of imm[20:1].
  - LUI: op 0110111, imm[31:12]; imm[11:0] ignored.
  - Fields not used by a format are zero.
- Illegal descriptors are accepted (handshake completes), not pushed, and raise err for exactly one cycle. A descriptor is illegal when any of the following holds:
  - class 7;
  - in_alu not in the supported set;
  - sub with OPIMM;
  - alu other than add for LOAD/STORE/JAL/LUI, or other than sub for BRANCH;
  - LOAD/STORE/OPIMM imm outside -2048..2047;
  - BRANCH imm outside -4096..4094 or odd;
  - JAL imm outside -1048576..1048574 or odd.
- Pointers wrap modulo DEPTH. Occupancy uses clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: INSTR_ENCODER_STATS_EN.
- When defined:
  - Adds output ports enc_count[15:0] (legal words pushed) and err_count[15:0] (illegal descriptors).
  - Both are cleared by reset, saturate at 0xFFFF, and are updated on the cycle after acceptance.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- OPIMM, add, rd=1, rs1=0, imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, err=0.
- OP, add, rd=3, rs1=1, rs2=2 -> 0x002081B3; same descriptor with sub -> 0x402081B3.
- LOAD, add, rd=2, rs1=0, imm=8 -> 0x00802103; BRANCH, sub, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- DEPTH=2, out_ready=0, three back-to-back descriptors -> in_ready=0 after two accepts, third held; raise out_ready -> words drain in order and the third is then accepted.
- OPIMM imm=4096, then BRANCH imm=3 -> err pulses one cycle each, no push, out_valid stays 0; with INSTR_ENCODER_STATS_EN, err_count=2 and enc_count=0.
- Fill the FIFO with two words, drop reset low for one cycle -> out_valid=0, in_ready=1, err=0; the next descriptor encodes normally.
